// File: rtl/riscv_pkg.sv
// Shared RV32 opcode constants, ALU control codes, ID/EX entry type and
// operand forwarding helper.
package riscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  aluctrl;
    logic [4:0]  rd;
    logic        illegal;
  } idex_ent_t;

  // MEM beats WB; x0 is never forwarded.
  function automatic logic [31:0] fwd_operand(
    input logic [4:0]  rs,
    input logic        mem_v,
    input logic [4:0]  mem_rd,
    input logic [31:0] mem_d,
    input logic        wb_v,
    input logic [4:0]  wb_rd,
    input logic [31:0] wb_d,
    input logic [31:0] rf_d
  );
    if (mem_v && (mem_rd != 5'd0) && (mem_rd == rs)) return mem_d;
    if (wb_v && (wb_rd != 5'd0) && (wb_rd == rs)) return wb_d;
    return rf_d;
  endfunction

endpackage

// File: rtl/idex_decode.sv
// Combinational ALU operand/control decode for the ID/EX stage.
module idex_decode
  import riscv_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  aluctrl,
  output logic        illegal
);

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    aluctrl = ALU_ADD;
    illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (funct7b5 && (funct3 != 3'b000) && (funct3 != 3'b101)) begin
          illegal = 1'b1;
        end else begin
          alu_a   = rs1_val;
          alu_b   = rs2_val;
          aluctrl = {funct7b5, funct3};
        end
      end
      OPC_OP_IMM: begin
        if ((funct3 == 3'b001) && funct7b5) begin
          illegal = 1'b1;
        end else begin
          alu_a   = rs1_val;
          alu_b   = imm;
          // Only shifts use bit 30; for ADDI it belongs to the immediate.
          aluctrl = {(funct3 == 3'b101) & funct7b5, funct3};
        end
      end
      OPC_LUI: begin
        alu_b = imm;
      end
      OPC_AUIPC: begin
        alu_a = pc;
        alu_b = imm;
      end
      OPC_LOAD, OPC_STORE: begin
        alu_a = rs1_val;
        alu_b = imm;
      end
      OPC_BRANCH: begin
        alu_a   = rs1_val;
        alu_b   = rs2_val;
        aluctrl = ALU_SUB;
      end
      OPC_JAL, OPC_JALR: begin
        alu_a = pc;
        alu_b = 32'd4;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with operand forwarding and valid/ready handshake.
// Define IDEX_SKID_EN to add a skid entry and register id_ready_o.
module idex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid_i,
  output logic            id_ready_o,
  input  logic [6:0]      id_opcode_i,
  input  logic [2:0]      id_funct3_i,
  input  logic            id_funct7b5_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [XLEN-1:0] id_imm_i,
  input  logic [XLEN-1:0] id_rs1_data_i,
  input  logic [XLEN-1:0] id_rs2_data_i,
  input  logic [4:0]      id_rs1_i,
  input  logic [4:0]      id_rs2_i,
  input  logic [4:0]      id_rd_i,
  input  logic            mem_fwd_valid_i,
  input  logic [4:0]      mem_fwd_rd_i,
  input  logic [XLEN-1:0] mem_fwd_data_i,
  input  logic            wb_fwd_valid_i,
  input  logic [4:0]      wb_fwd_rd_i,
  input  logic [XLEN-1:0] wb_fwd_data_i,
  input  logic            flush_i,
  output logic            ex_valid_o,
  input  logic            ex_ready_i,
  output logic [XLEN-1:0] ex_alu_a_o,
  output logic [XLEN-1:0] ex_alu_b_o,
  output logic [3:0]      ex_aluctrl_o,
  output logic [4:0]      ex_rd_o,
  output logic            ex_illegal_o
);

  logic [31:0] rs1_val, rs2_val;
  logic [31:0] dec_a, dec_b;
  logic [3:0]  dec_ctrl;
  logic        dec_illegal;
  idex_ent_t   new_ent, out_ent;
  logic        out_valid;
  logic        capture;

  assign rs1_val = fwd_operand(id_rs1_i, mem_fwd_valid_i, mem_fwd_rd_i, mem_fwd_data_i,
                               wb_fwd_valid_i, wb_fwd_rd_i, wb_fwd_data_i, id_rs1_data_i);
  assign rs2_val = fwd_operand(id_rs2_i, mem_fwd_valid_i, mem_fwd_rd_i, mem_fwd_data_i,
                               wb_fwd_valid_i, wb_fwd_rd_i, wb_fwd_data_i, id_rs2_data_i);

  idex_decode u_decode (
    .opcode   (id_opcode_i),
    .funct3   (id_funct3_i),
    .funct7b5 (id_funct7b5_i),
    .pc       (id_pc_i),
    .imm      (id_imm_i),
    .rs1_val  (rs1_val),
    .rs2_val  (rs2_val),
    .alu_a    (dec_a),
    .alu_b    (dec_b),
    .aluctrl  (dec_ctrl),
    .illegal  (dec_illegal)
  );

  assign new_ent = '{a: dec_a, b: dec_b, aluctrl: dec_ctrl, rd: id_rd_i, illegal: dec_illegal};
  assign capture = id_valid_i && id_ready_o;

`ifdef IDEX_SKID_EN
  idex_ent_t skid_ent;
  logic      skid_valid;

  // skid_valid is a flop, so ready is registered and never depends on ex_ready_i.
  assign id_ready_o = !skid_valid;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      out_valid  <= 1'b0;
      out_ent    <= '0;
      skid_valid <= 1'b0;
      skid_ent   <= '0;
    end else if (out_valid && !ex_ready_i) begin
      if (capture) begin
        skid_valid <= 1'b1;
        skid_ent   <= new_ent;
      end
    end else if (skid_valid) begin
      out_valid  <= 1'b1;
      out_ent    <= skid_ent;
      skid_valid <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_ent   <= new_ent;
    end else begin
      out_valid <= 1'b0;
    end
  end
`else
  assign id_ready_o = !out_valid || ex_ready_i;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      out_valid <= 1'b0;
      out_ent   <= '0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_ent   <= new_ent;
    end else if (ex_ready_i) begin
      out_valid <= 1'b0;
    end
  end
`endif

  assign ex_valid_o   = out_valid;
  assign ex_alu_a_o   = out_ent.a;
  assign ex_alu_b_o   = out_ent.b;
  assign ex_aluctrl_o = out_ent.aluctrl;
  assign ex_rd_o      = out_ent.rd;
  assign ex_illegal_o = out_valid && out_ent.illegal;

endmodule

// File: tb/tb_idex_stage.sv
// Self-checking bench for idex_stage: queue-based reference model plus
// directed literal cases; works with or without IDEX_SKID_EN.
module tb_idex_stage;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        ill;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid_i, id_ready_o;
  logic [6:0]  id_opcode_i;
  logic [2:0]  id_funct3_i;
  logic        id_funct7b5_i;
  logic [31:0] id_pc_i, id_imm_i, id_rs1_data_i, id_rs2_data_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic        mem_fwd_valid_i, wb_fwd_valid_i;
  logic [4:0]  mem_fwd_rd_i, wb_fwd_rd_i;
  logic [31:0] mem_fwd_data_i, wb_fwd_data_i;
  logic        flush_i;
  logic        ex_valid_o, ex_ready_i;
  logic [31:0] ex_alu_a_o, ex_alu_b_o;
  logic [3:0]  ex_aluctrl_o;
  logic [4:0]  ex_rd_o;
  logic        ex_illegal_o;

  int   n_checks = 0;
  int   n_fail   = 0;
  ent_t q[$];
  logic [4:0] retired[$];
  logic [6:0] ops[10] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h7f};

  idex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
    .id_opcode_i(id_opcode_i), .id_funct3_i(id_funct3_i), .id_funct7b5_i(id_funct7b5_i),
    .id_pc_i(id_pc_i), .id_imm_i(id_imm_i),
    .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .mem_fwd_valid_i(mem_fwd_valid_i), .mem_fwd_rd_i(mem_fwd_rd_i), .mem_fwd_data_i(mem_fwd_data_i),
    .wb_fwd_valid_i(wb_fwd_valid_i), .wb_fwd_rd_i(wb_fwd_rd_i), .wb_fwd_data_i(wb_fwd_data_i),
    .flush_i(flush_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .ex_alu_a_o(ex_alu_a_o), .ex_alu_b_o(ex_alu_b_o), .ex_aluctrl_o(ex_aluctrl_o),
    .ex_rd_o(ex_rd_o), .ex_illegal_o(ex_illegal_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_fwd(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 0) return rf;
    if (mem_fwd_valid_i && mem_fwd_rd_i == rs) return mem_fwd_data_i;
    if (wb_fwd_valid_i && wb_fwd_rd_i == rs) return wb_fwd_data_i;
    return rf;
  endfunction

  function automatic ent_t ref_entry();
    ent_t e;
    logic [31:0] v1, v2;
    v1 = ref_fwd(id_rs1_i, id_rs1_data_i);
    v2 = ref_fwd(id_rs2_i, id_rs2_data_i);
    e = '{a: 0, b: 0, ctrl: 0, rd: id_rd_i, ill: 0};
    case (id_opcode_i)
      7'h33:
        if (id_funct7b5_i && id_funct3_i != 0 && id_funct3_i != 5) e.ill = 1;
        else begin e.a = v1; e.b = v2; e.ctrl = {id_funct7b5_i, id_funct3_i}; end
      7'h13:
        if (id_funct3_i == 1 && id_funct7b5_i) e.ill = 1;
        else begin
          e.a = v1; e.b = id_imm_i;
          e.ctrl = {(id_funct3_i == 5) ? id_funct7b5_i : 1'b0, id_funct3_i};
        end
      7'h37: e.b = id_imm_i;
      7'h17: begin e.a = id_pc_i; e.b = id_imm_i; end
      7'h03, 7'h23: begin e.a = v1; e.b = id_imm_i; end
      7'h63: begin e.a = v1; e.b = v2; e.ctrl = 4'b1000; end
      7'h6f, 7'h67: begin e.a = id_pc_i; e.b = 4; end
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  task automatic compare();
    chk("ex_valid", ex_valid_o, q.size() > 0);
    chk("ex_illegal", ex_illegal_o, (q.size() > 0) ? q[0].ill : 1'b0);
    if (q.size() > 0) begin
      chk("ex_alu_a", ex_alu_a_o, q[0].a);
      chk("ex_alu_b", ex_alu_b_o, q[0].b);
      chk("ex_aluctrl", ex_aluctrl_o, q[0].ctrl);
      chk("ex_rd", ex_rd_o, q[0].rd);
    end
  endtask

  // Inputs are already driven; advance one clock, update the model, compare.
  task automatic cycle(output bit acc);
    bit   rdy;
    ent_t e;
    #1;
`ifdef IDEX_SKID_EN
    rdy = q.size() < 2;
`else
    rdy = (q.size() == 0) || ex_ready_i;
`endif
    chk("id_ready", id_ready_o, rdy);
    acc = id_valid_i && rdy;
    if (ex_valid_o && ex_ready_i && !rst && !flush_i) retired.push_back(ex_rd_o);
    e = ref_entry();
    @(posedge clk);
    if (rst || flush_i) q.delete();
    else begin
      if (q.size() > 0 && ex_ready_i) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    @(negedge clk);
    compare();
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                           input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm);
    id_opcode_i = op; id_funct3_i = f3; id_funct7b5_i = f7;
    id_rs1_i = r1; id_rs2_i = r2; id_rd_i = rd;
    id_rs1_data_i = d1; id_rs2_data_i = d2; id_imm_i = imm; id_pc_i = 32'h100;
  endtask

  initial begin
    bit acc;
    int k;
    rst = 1; flush_i = 0; id_valid_i = 0; ex_ready_i = 0;
    mem_fwd_valid_i = 0; mem_fwd_rd_i = 0; mem_fwd_data_i = 0;
    wb_fwd_valid_i = 0; wb_fwd_rd_i = 0; wb_fwd_data_i = 0;
    set_instr(7'h33, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    cycle(acc);
    cycle(acc);
    rst = 0;
    #0;
    chk("rst_valid", ex_valid_o, 0);
    chk("rst_a", ex_alu_a_o, 0);
    chk("rst_b", ex_alu_b_o, 0);
    chk("rst_ctrl", ex_aluctrl_o, 0);
    chk("rst_rd", ex_rd_o, 0);
    chk("rst_illegal", ex_illegal_o, 0);
    chk("rst_ready", id_ready_o, 1);

    ex_ready_i = 1; id_valid_i = 1;
    set_instr(7'h33, 3'b101, 1, 1, 2, 3, 32'h8000_0000, 32'd4, 0);
    cycle(acc);
    chk("sra_valid", ex_valid_o, 1);
    chk("sra_ctrl", ex_aluctrl_o, 4'b1101);
    chk("sra_a", ex_alu_a_o, 32'h8000_0000);
    chk("sra_b", ex_alu_b_o, 32'd4);

    set_instr(7'h13, 3'b000, 1, 1, 2, 4, 32'h7, 0, 32'hFFFF_FFFF);
    cycle(acc);
    chk("addi_ctrl", ex_aluctrl_o, 4'b0000);
    chk("addi_b", ex_alu_b_o, 32'hFFFF_FFFF);

    set_instr(7'h33, 0, 0, 5, 6, 7, 32'h33, 32'h44, 0);
    mem_fwd_valid_i = 1; mem_fwd_rd_i = 5; mem_fwd_data_i = 32'h11;
    wb_fwd_valid_i = 1; wb_fwd_rd_i = 5; wb_fwd_data_i = 32'h22;
    cycle(acc);
    chk("fwd_mem_prio", ex_alu_a_o, 32'h11);
    set_instr(7'h33, 0, 0, 0, 6, 7, 32'h1234, 32'h44, 0);
    mem_fwd_rd_i = 0; mem_fwd_data_i = 32'h99;
    cycle(acc);
    chk("fwd_x0", ex_alu_a_o, 32'h1234);
    mem_fwd_valid_i = 0; wb_fwd_valid_i = 0;

    flush_i = 1;
    cycle(acc);
    chk("flush_valid", ex_valid_o, 0);
    flush_i = 0;
    set_instr(7'h7f, 0, 0, 1, 2, 9, 32'h55, 32'h66, 32'h77);
    cycle(acc);
    chk("ill_flag", ex_illegal_o, 1);
    chk("ill_a", ex_alu_a_o, 0);
    chk("ill_b", ex_alu_b_o, 0);

    // Stream of three with the consumer stalled for three cycles.
    id_valid_i = 0; cycle(acc);
    retired.delete();
    k = 0;
    for (int c = 0; c < 16; c++) begin
      ex_ready_i = (c >= 3);
      id_valid_i = (k < 3);
      set_instr(7'h33, 3'b110, 0, 1, 2, 5'(k + 1), 32'h10 * (k + 1), 32'h3, 0);
      cycle(acc);
      if (acc) k++;
    end
    chk("stream_count", retired.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("stream_order", (i < retired.size()) ? retired[i] : 5'h1f, 5'(i + 1));

    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      flush_i = ($urandom_range(0, 39) == 0);
      id_valid_i = ($urandom_range(0, 4) != 0);
      ex_ready_i = ($urandom_range(0, 9) < 7);
      set_instr(ops[$urandom_range(0, 9)], 3'($urandom), 1'($urandom),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom),
                $urandom, $urandom, $urandom);
      id_pc_i = $urandom;
      if ($urandom_range(0, 19) == 0) id_opcode_i = 7'($urandom);
      mem_fwd_valid_i = 1'($urandom); mem_fwd_rd_i = 5'($urandom_range(0, 3)); mem_fwd_data_i = $urandom;
      wb_fwd_valid_i = 1'($urandom); wb_fwd_rd_i = 5'($urandom_range(0, 3)); wb_fwd_data_i = $urandom;
      cycle(acc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/idex_stage.md
IDEX_STAGE -- requirements
Module: idex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have ports clk in 1, rising-edge clock; rst in 1, reset, synchronous, active-high.
REQ-003 SHALL have upstream ports id_valid_i in 1; id_ready_o out 1; id_opcode_i in 7; id_funct3_i in 3; id_funct7b5_i in 1, instruction bit 30.
REQ-004 SHALL have upstream ports id_pc_i in 32; id_imm_i in 32, sign-extended immediate; id_rs1_data_i, id_rs2_data_i in 32, regfile reads; id_rs1_i, id_rs2_i, id_rd_i in 5.
REQ-005 SHALL have forwarding ports mem_fwd_valid_i in 1, mem_fwd_rd_i in 5, mem_fwd_data_i in 32, and wb_fwd_valid_i in 1, wb_fwd_rd_i in 5, wb_fwd_data_i in 32.
REQ-006 SHALL have flush_i in 1, kill all held instructions.
REQ-007 SHALL have downstream ports ex_valid_o out 1; ex_ready_i in 1; ex_alu_a_o, ex_alu_b_o out 32; ex_aluctrl_o out 4, ALU control code; ex_rd_o out 5; ex_illegal_o out 1.

Function
REQ-008 SHALL, for OP (0110011), drive aluctrl[2:0]=funct3 and aluctrl[3]=funct7b5, with a=rs1 and b=rs2.
REQ-009 SHALL, for OP-IMM (0010011), drive aluctrl[2:0]=funct3, aluctrl[3]=funct7b5 only when funct3=101 (else 0), with a=rs1 and b=imm.
REQ-010 SHALL, for LUI, drive a=0, b=imm, ADD (0000); for AUIPC, drive a=pc, b=imm, ADD.
REQ-011 SHALL, for LOAD/STORE, drive a=rs1, b=imm, ADD; for BRANCH, drive a=rs1, b=rs2, SUB (1000); for JAL/JALR, drive a=pc, b=4, ADD.
REQ-012 SHALL flag illegal for: any other opcode; OP with funct7b5=1 and funct3 not in {000,101}; OP-IMM funct3=001 with funct7b5=1.
REQ-013 SHALL, for an illegal instruction, pass it with ex_illegal_o=1, a=b=0, aluctrl=0000.
REQ-014 SHALL resolve rs1 operand as: MEM match (valid, rd!=0, rd==rs1) -> mem data; else WB match -> wb data; else id_rs1_data_i; rs2 likewise.
REQ-015 SHALL apply MEM priority over WB when both match; x0 SHALL never be forwarded.
REQ-016 SHALL resolve operands in the cycle of the ID handshake; held entries SHALL NOT re-forward.
REQ-017 SHALL transfer upstream only when id_valid_i && id_ready_o; an output entry SHALL retire only when ex_valid_o && ex_ready_i.
REQ-018 SHALL hold all ex_* outputs stable while ex_valid_o=1 and ex_ready_i=0.
REQ-019 SHALL give 1-cycle latency: an instruction accepted at edge N appears on ex_* after edge N.
REQ-020 SHALL sustain back-to-back throughput of one instruction per cycle when ex_ready_i=1.
REQ-021 SHALL, on flush_i at an edge, clear ex_valid_o, ex_illegal_o and all buffered entries next cycle; flush SHALL win over a simultaneous capture.
REQ-022 SHALL keep ex_illegal_o=0 whenever ex_valid_o=0.

Reset
REQ-023 SHALL, with rst high at an edge, set ex_valid_o=0, ex_alu_a_o=ex_alu_b_o=0, ex_aluctrl_o=0000, ex_rd_o=0 and ex_illegal_o=0, and empty all buffers.
REQ-024 SHALL take priority of reset over flush_i and capture; id_ready_o SHALL be 1 in the first cycle after reset.
REQ-025 SHALL discard any in-flight instruction on reset mid-operation; no partial output.

Configuration
REQ-026 SHALL provide macro IDEX_SKID_EN.
REQ-027 SHALL, without IDEX_SKID_EN, use a single entry with id_ready_o = !ex_valid_o || ex_ready_i, combinational.
REQ-028 SHALL, with IDEX_SKID_EN, add one skid entry: id_ready_o = skid empty, registered; a capture while output stalls SHALL fill the skid; the skid SHALL refill the output on retire; order SHALL be preserved.

Structure
REQ-029 SHALL place opcode constants and ALU control codes (ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111) in shared package riscv_pkg.
REQ-030 SHALL implement the combinational decode of REQ-008..013 as sub-module idex_decode.

Verification
REQ-031 SHALL verify: OP funct3=101, funct7b5=1, rs1=0x80000000, rs2=4 -> next cycle ex_aluctrl_o=1101, a=0x80000000, b=4, valid=1.
REQ-032 SHALL verify: OP-IMM funct3=000, funct7b5=1, imm=0xFFFFFFFF -> aluctrl=0000 (ADDI, not SUB), b=0xFFFFFFFF.
REQ-033 SHALL verify: rs1=5 with MEM rd=5 data 0x11 and WB rd=5 data 0x22 both valid -> a=0x11; rs1=0 with MEM rd=0 -> a=id_rs1_data_i.
REQ-034 SHALL verify: ex_ready_i=0 for 3 cycles with stream of 3 -> outputs stable, no loss or duplication, order kept (both macro settings).
REQ-035 SHALL verify: flush_i with id_valid_i=1 at same edge -> ex_valid_o=0 next cycle; opcode 1111111 -> ex_illegal_o=1, a=b=0.
